// File: rtl/fp_result_pack.sv
// fp_result_pack: final normalize / round / pack stage of the FP pipeline.
// Two registered stages with no backpressure:
//   stage A - capture the beat; per lane, fold a carry (bit27) with a sticky
//             right shift, or count leading zeros for the left normalization.
//   stage B - normalize, round to nearest even, apply special cases, pack.
// Writeback rollback squashes a thread's beat at input capture and in stage A.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   wb_rollback_en/_thread_idx   rollback request and thread
//   in_valid, in_thread_idx      input beat valid and issuing thread
//   in_mask                      lane mask, carried through unchanged
//   in_is_ftoi                   integer result, significand passes raw
//   in_sign/in_exponent          per-lane sign and biased exponent
//   in_significand               per-lane magnitude (bit27 carry, bit26 hidden,
//                                bits25:3 fraction, bits2:0 guard/round/sticky)
//   in_is_nan/in_is_inf          per-lane special-case forcing
//   out_valid/out_thread_idx/out_mask/out_result   registered result beat
module fp_result_pack #(
    parameter int NUM_LANES = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      wb_rollback_en,
    input  logic [1:0]                wb_rollback_thread_idx,
    input  logic                      in_valid,
    input  logic [1:0]                in_thread_idx,
    input  logic [NUM_LANES-1:0]      in_mask,
    input  logic                      in_is_ftoi,
    input  logic [NUM_LANES-1:0]      in_sign,
    input  logic [NUM_LANES*8-1:0]    in_exponent,
    input  logic [NUM_LANES*32-1:0]   in_significand,
    input  logic [NUM_LANES-1:0]      in_is_nan,
    input  logic [NUM_LANES-1:0]      in_is_inf,
    output logic                      out_valid,
    output logic [1:0]                out_thread_idx,
    output logic [NUM_LANES-1:0]      out_mask,
    output logic [NUM_LANES*32-1:0]   out_result
);

    // Stage A per-lane state: significand (raw for ftoi, otherwise with the
    // carry folded in so bit27 is clear), 10-bit signed pre-exponent, shift.
    typedef struct packed {
        logic [31:0] sig;
        logic [9:0]  exp;
        logic [4:0]  shift;
    } pre_t;

    function automatic logic [4:0] count_lz(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int unsigned j = 0; j < 27; j++) begin
            if (v[j]) n = 5'(26 - j);
        end
        return n;
    endfunction

    function automatic pre_t prenorm(input logic [31:0] sig, input logic [7:0] exp,
                                     input logic ftoi);
        pre_t       p;
        logic [4:0] lz;
        p.sig   = sig;
        p.exp   = {2'b00, exp};
        p.shift = '0;
        if (!ftoi) begin
            if (sig[27]) begin
                p.sig = {5'b0, sig[27:2], sig[1] | sig[0]};
                p.exp = {2'b00, exp} + 10'd1;
            end else begin
                lz      = count_lz(sig[26:0]);
                p.sig   = {4'b0, sig[27:0]};
                p.exp   = {2'b00, exp} - {5'b0, lz};
                p.shift = lz;
            end
        end
        return p;
    endfunction

    function automatic logic [31:0] pack_lane(input pre_t p, input logic sign,
                                              input logic nan, input logic inf,
                                              input logic ftoi);
        logic [26:0] norm;
        logic        round_up;
        logic        carry;
        logic [22:0] frac;
        logic [9:0]  fexp;
        norm     = p.sig[26:0] << p.shift;
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        // Hidden bit is 1 for any nonzero value, so a carry out of the
        // fraction field is the carry into bit27; frac is then already zero.
        {carry, frac} = {1'b0, norm[25:3]} + 24'(round_up);
        fexp = carry ? p.exp + 10'd1 : p.exp;
        if (nan)                          return 32'h7fffffff;
        else if (inf)                     return {sign, 8'hff, 23'd0};
        else if (ftoi)                    return p.sig;
        else if (!norm[26])               return {sign, 31'd0};
        else if ($signed(fexp) >= 10'sd255) return {sign, 8'hff, 23'd0};
        else if ($signed(fexp) <= 10'sd0)   return {sign, 31'd0};
        else                              return {sign, fexp[7:0], frac};
    endfunction

    logic                    a_valid;
    logic [1:0]              a_thread;
    logic [NUM_LANES-1:0]    a_mask;
    logic                    a_ftoi;
    logic [NUM_LANES-1:0]    a_sign;
    logic [NUM_LANES-1:0]    a_nan;
    logic [NUM_LANES-1:0]    a_inf;
    pre_t [NUM_LANES-1:0]    a_pre;
    pre_t [NUM_LANES-1:0]    a_pre_d;
    logic [NUM_LANES-1:0][31:0] out_d;
    logic                    drop_in;
    logic                    drop_a;

    assign drop_in = wb_rollback_en && (wb_rollback_thread_idx == in_thread_idx);
    assign drop_a  = wb_rollback_en && (wb_rollback_thread_idx == a_thread);

    always_comb begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            a_pre_d[i] = prenorm(in_significand[i*32 +: 32], in_exponent[i*8 +: 8], in_is_ftoi);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            out_d[i] = pack_lane(a_pre[i], a_sign[i], a_nan[i], a_inf[i], a_ftoi);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_valid  <= 1'b0;
            a_thread <= '0;
            a_mask   <= '0;
            a_ftoi   <= 1'b0;
            a_sign   <= '0;
            a_nan    <= '0;
            a_inf    <= '0;
            a_pre    <= '0;
        end else begin
            a_valid  <= in_valid && !drop_in;
            a_thread <= in_thread_idx;
            a_mask   <= in_mask;
            a_ftoi   <= in_is_ftoi;
            a_sign   <= in_sign;
            a_nan    <= in_is_nan;
            a_inf    <= in_is_inf;
            a_pre    <= a_pre_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid      <= 1'b0;
            out_thread_idx <= '0;
            out_mask       <= '0;
            out_result     <= '0;
        end else begin
            out_valid      <= a_valid && !drop_a;
            out_thread_idx <= a_thread;
            out_mask       <= a_mask;
            out_result     <= out_d;
        end
    end

endmodule

// File: tb/tb_fp_result_pack.sv
// Testbench for fp_result_pack: table of directed lane-0 vectors, hand-written
// rollback / reset sequences, and a randomized phase. Every cycle the outputs
// are compared against an arithmetic reference model of IEEE single rounding.
module tb_fp_result_pack;
    localparam int NL = 16;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 wb_rollback_en;
    logic [1:0]           wb_rollback_thread_idx;
    logic                 in_valid;
    logic [1:0]           in_thread_idx;
    logic [NL-1:0]        in_mask;
    logic                 in_is_ftoi;
    logic [NL-1:0]        in_sign;
    logic [NL*8-1:0]      in_exponent;
    logic [NL*32-1:0]     in_significand;
    logic [NL-1:0]        in_is_nan;
    logic [NL-1:0]        in_is_inf;
    logic                 out_valid;
    logic [1:0]           out_thread_idx;
    logic [NL-1:0]        out_mask;
    logic [NL*32-1:0]     out_result;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_result_pack #(.NUM_LANES(NL)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .wb_rollback_en(wb_rollback_en),
        .wb_rollback_thread_idx(wb_rollback_thread_idx),
        .in_valid(in_valid),
        .in_thread_idx(in_thread_idx),
        .in_mask(in_mask),
        .in_is_ftoi(in_is_ftoi),
        .in_sign(in_sign),
        .in_exponent(in_exponent),
        .in_significand(in_significand),
        .in_is_nan(in_is_nan),
        .in_is_inf(in_is_inf),
        .out_valid(out_valid),
        .out_thread_idx(out_thread_idx),
        .out_mask(out_mask),
        .out_result(out_result)
    );

    typedef struct {
        logic             valid;
        logic [1:0]       thread;
        logic [NL-1:0]    mask;
        logic             ftoi;
        logic [NL-1:0]    sign;
        logic [NL-1:0]    nan;
        logic [NL-1:0]    inf;
        logic [NL*8-1:0]  exps;
        logic [NL*32-1:0] sigs;
        logic             rb_en;
        logic [1:0]       rb_thr;
        logic             rst;
    } beat_t;

    typedef struct {
        string       name;
        logic        sign;
        logic [7:0]  exp;
        logic [31:0] sig;
        logic        nan;
        logic        inf;
        logic        ftoi;
        logic [31:0] want;
    } vec_t;

    beat_t prev;
    beat_t cur;
    vec_t  vecs[$];

    // Reference: value = sig[27:0] * 2^(exp-127-26); keep 24 significant bits
    // with exact round-half-even on the discarded remainder.
    function automatic logic [31:0] model_lane(input logic s, input logic [7:0] e,
                                               input logic [31:0] sig, input logic nan,
                                               input logic inf, input logic ftoi);
        longint m, q, r, half;
        int p, k, ex;
        if (nan) return 32'h7fffffff;
        if (inf) return {s, 8'hff, 23'd0};
        if (ftoi) return sig;
        m = longint'(sig[27:0]);
        if (m == 0) return {s, 31'd0};
        p = 27;
        while (((m >> p) & 1) == 0) p--;
        ex = int'(e) + p - 26;
        if (p > 23) begin
            k = p - 23;
            q = m >> k;
            r = m - (q << k);
            half = longint'(1) << (k - 1);
            if (r > half || (r == half && (q & 1) == 1)) q++;
        end else begin
            q = m << (23 - p);
        end
        if (q == (longint'(1) << 24)) begin
            q = q >> 1;
            ex++;
        end
        if (ex >= 255) return {s, 8'hff, 23'd0};
        if (ex <= 0) return {s, 31'd0};
        return {s, 8'(ex), 23'(q)};
    endfunction

    function automatic logic [NL*32-1:0] model_vec(input beat_t b);
        logic [NL*32-1:0] v;
        for (int unsigned l = 0; l < NL; l++) begin
            v[l*32 +: 32] = model_lane(b.sign[l], b.exps[l*8 +: 8], b.sigs[l*32 +: 32],
                                       b.nan[l], b.inf[l], b.ftoi);
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [NL*32-1:0] got,
                         input logic [NL*32-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic check_out();
        logic ev;
        if (cur.rst) begin
            check("rst_valid", out_valid, 0);
            check("rst_thread", out_thread_idx, 0);
            check("rst_mask", out_mask, 0);
            check("rst_result", out_result, 0);
        end else begin
            ev = prev.valid && !prev.rst
                 && !(prev.rb_en && prev.rb_thr == prev.thread)
                 && !(cur.rb_en && cur.rb_thr == prev.thread);
            check("sb_valid", out_valid, ev);
            if (ev) begin
                check("sb_thread", out_thread_idx, prev.thread);
                check("sb_mask", out_mask, prev.mask);
                check("sb_result", out_result, model_vec(prev));
            end
        end
    endtask

    task automatic tick();
        cur.valid  = in_valid;
        cur.thread = in_thread_idx;
        cur.mask   = in_mask;
        cur.ftoi   = in_is_ftoi;
        cur.sign   = in_sign;
        cur.nan    = in_is_nan;
        cur.inf    = in_is_inf;
        cur.exps   = in_exponent;
        cur.sigs   = in_significand;
        cur.rb_en  = wb_rollback_en;
        cur.rb_thr = wb_rollback_thread_idx;
        cur.rst    = !reset_n;
        @(posedge clk);
        #1;
        check_out();
        prev = cur;
    endtask

    task automatic rand_lanes(input logic ftoi);
        logic [31:0] s;
        for (int unsigned l = 0; l < NL; l++) begin
            case ($urandom_range(0, 3))
                0: s = {4'h0, 28'($urandom)};
                1: s = {4'h0, 28'($urandom)} >> $urandom_range(0, 28);
                2: s = 32'h04000000 | 32'($urandom_range(0, 15));
                default: s = 32'h07FFFFF0 | 32'($urandom_range(0, 15));
            endcase
            if (ftoi) s = $urandom;
            in_significand[l*32 +: 32] = s;
            in_exponent[l*8 +: 8]      = 8'($urandom);
            in_sign[l]                 = 1'($urandom);
            in_is_nan[l]               = ($urandom_range(0, 15) == 0);
            in_is_inf[l]               = ($urandom_range(0, 15) == 0);
        end
    endtask

    task automatic idle();
        in_valid       = 1'b0;
        wb_rollback_en = 1'b0;
    endtask

    task automatic add_vec(input string n, input logic s, input logic [7:0] e,
                           input logic [31:0] sig, input logic nan, input logic inf,
                           input logic ftoi, input logic [31:0] want);
        vec_t v;
        v.name = n; v.sign = s; v.exp = e; v.sig = sig;
        v.nan = nan; v.inf = inf; v.ftoi = ftoi; v.want = want;
        vecs.push_back(v);
    endtask

    initial begin
        add_vec("one",        0, 8'd127, 32'h04000000, 0, 0, 0, 32'h3f800000);
        add_vec("carry",      0, 8'd127, 32'h08000000, 0, 0, 0, 32'h40000000);
        add_vec("tie_even",   0, 8'd127, 32'h04000004, 0, 0, 0, 32'h3f800000);
        add_vec("tie_odd",    0, 8'd127, 32'h0400000C, 0, 0, 0, 32'h3f800002);
        add_vec("above_half", 0, 8'd127, 32'h04000005, 0, 0, 0, 32'h3f800001);
        add_vec("round_carry",0, 8'd127, 32'h07FFFFFC, 0, 0, 0, 32'h40000000);
        add_vec("overflow",   0, 8'd254, 32'h08000000, 0, 0, 0, 32'h7f800000);
        add_vec("exp255",     1, 8'd255, 32'h04000000, 0, 0, 0, 32'hff800000);
        add_vec("underflow",  0, 8'd1,   32'h02000000, 0, 0, 0, 32'h00000000);
        add_vec("exp0",       0, 8'd0,   32'h04000000, 0, 0, 0, 32'h00000000);
        add_vec("neg_zero",   1, 8'd100, 32'h00000000, 0, 0, 0, 32'h80000000);
        add_vec("nan",        1, 8'd5,   32'h00000123, 1, 0, 0, 32'h7fffffff);
        add_vec("nan_inf",    1, 8'd5,   32'h00000123, 1, 1, 0, 32'h7fffffff);
        add_vec("neg_inf",    1, 8'd5,   32'h00000123, 0, 1, 0, 32'hff800000);
        add_vec("inf_ftoi",   0, 8'd5,   32'h00000123, 0, 1, 1, 32'h7f800000);
        add_vec("ftoi",       0, 8'd0,   32'hFFFFFFF9, 0, 0, 1, 32'hFFFFFFF9);
        add_vec("norm_shift", 0, 8'd150, 32'h00000040, 0, 0, 0, 32'h41000000);

        prev.valid = 1'b0;
        prev.rst   = 1'b1;
        reset_n = 1'b0;
        wb_rollback_thread_idx = '0;
        in_thread_idx = '0;
        in_mask = '0;
        in_is_ftoi = 1'b0;
        idle();
        rand_lanes(1'b0);
        tick();
        tick();
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            in_is_ftoi = vecs[i].ftoi;
            rand_lanes(vecs[i].ftoi);
            in_valid = 1'b1;
            in_thread_idx = 2'($urandom);
            in_mask = NL'($urandom);
            in_sign[0] = vecs[i].sign;
            in_exponent[7:0] = vecs[i].exp;
            in_significand[31:0] = vecs[i].sig;
            in_is_nan[0] = vecs[i].nan;
            in_is_inf[0] = vecs[i].inf;
            tick();
            idle();
            check({vecs[i].name, "_early"}, out_valid, 0);
            tick();
            check({vecs[i].name, "_valid"}, out_valid, 1);
            check(vecs[i].name, out_result[31:0], vecs[i].want);
        end

        // Rollback of the thread sitting in stage A.
        in_is_ftoi = 1'b0;
        rand_lanes(1'b0);
        in_valid = 1'b1;
        in_thread_idx = 2'd1;
        tick();
        rand_lanes(1'b0);
        in_thread_idx = 2'd2;
        wb_rollback_en = 1'b1;
        wb_rollback_thread_idx = 2'd1;
        tick();
        check("rb_stage_a_drop", out_valid, 0);
        idle();
        tick();
        check("rb_t2_valid", out_valid, 1);
        check("rb_t2_thread", out_thread_idx, 2);
        tick();
        check("rb_after", out_valid, 0);

        // Rollback matching the input thread, then a non-matching one.
        rand_lanes(1'b0);
        in_valid = 1'b1;
        in_thread_idx = 2'd3;
        wb_rollback_en = 1'b1;
        wb_rollback_thread_idx = 2'd3;
        tick();
        rand_lanes(1'b0);
        in_thread_idx = 2'd0;
        tick();
        check("rb_in_drop", out_valid, 0);
        idle();
        tick();
        check("rb_other_kept", out_valid, 1);
        check("rb_other_thread", out_thread_idx, 0);

        // Reset with two beats in flight.
        rand_lanes(1'b0);
        in_valid = 1'b1;
        in_thread_idx = 2'd1;
        tick();
        rand_lanes(1'b0);
        in_thread_idx = 2'd2;
        tick();
        check("pre_rst_valid", out_valid, 1);
        reset_n = 1'b0;
        tick();
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_result", out_result, 0);
        reset_n = 1'b1;
        idle();
        tick();
        check("rst_no_stale", out_valid, 0);
        rand_lanes(1'b0);
        in_valid = 1'b1;
        in_thread_idx = 2'd3;
        tick();
        check("rst_new_early", out_valid, 0);
        idle();
        tick();
        check("rst_new_valid", out_valid, 1);
        check("rst_new_thread", out_thread_idx, 3);

        // Randomized traffic with rollbacks and occasional resets.
        for (int unsigned c = 0; c < 400; c++) begin
            in_is_ftoi = ($urandom_range(0, 7) == 0);
            rand_lanes(in_is_ftoi);
            in_valid = ($urandom_range(0, 9) < 8);
            in_thread_idx = 2'($urandom);
            in_mask = NL'($urandom);
            wb_rollback_en = ($urandom_range(0, 3) == 0);
            wb_rollback_thread_idx = 2'($urandom);
            reset_n = ($urandom_range(0, 49) != 0);
            tick();
        end
        reset_n = 1'b1;
        idle();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_result_pack.md
# fp_result_pack

Final normalize/round/pack stage of the floating point pipeline. It takes unnormalized per-lane sum or product magnitudes with an exponent, sign and special-case flags, and produces IEEE-754 single precision results. Float-to-int results pass through unchanged. It is a fixed two-stage pipeline with no backpressure. It squashes in-flight work for a thread on writeback rollback.

## Interface
- NUM_LANES, 16, number of vector lanes processed in parallel
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- wb_rollback_en  in  1  rollback request from writeback
- wb_rollback_thread_idx  in  2  thread being rolled back
- in_valid  in  1  input beat valid
- in_thread_idx  in  2  issuing thread
- in_mask  in  NUM_LANES  lane enable mask; carried through only
- in_is_ftoi  in  1  integer result: pass in_significand through raw
- in_sign  in  NUM_LANES  per-lane result sign
- in_exponent  in  NUM_LANES×8  per-lane biased exponent
- in_significand  in  NUM_LANES×32  per-lane magnitude; bit27 carry, bit26 hidden, bits25:3 fraction, bits2:0 guard/round/sticky
- in_is_nan  in  NUM_LANES  force NaN
- in_is_inf  in  NUM_LANES  force signed infinity
- out_valid  out  1  result valid
- out_thread_idx  out  2  thread of result
- out_mask  out  NUM_LANES  mask of result
- out_result  out  NUM_LANES×32  packed per-lane results

## Operation
- Stage A, registered at the first edge after input:
  - Capture valid, thread, mask, ftoi flag, sign and flags.
  - Per lane, if bit27=1: shift right 1. The shifted-out bit is ORed into bit0 (sticky). Pre-exponent = exp+1.
  - Otherwise compute lz = leading zeros in bits26:0 (0..27). Pre-exponent = exp − lz, held as 10-bit signed. Shift amount = lz.
- Stage B, registered at the second edge:
  - Left-shift by lz. Round to nearest even: increment at bit3 when bit2 & (bit1 | bit0 | bit3).
  - A rounding carry into bit27 gives exponent+1 and fraction 0.
- Per-lane result priority, highest first:
  1. in_is_nan → 32'h7fffffff.
  2. in_is_inf → {sign, 8'hff, 23'd0}.
  3. in_is_ftoi → in_significand unchanged.
  4. Significand zero → {sign, 31'd0}.
  5. Final exponent ≥ 255 → {sign, 8'hff, 23'd0}.
  6. Final exponent ≤ 0 → {sign, 31'd0}. Subnormals flush to zero.
  7. Otherwise → {sign, exp[7:0], fraction bits25:3 after rounding}.
- Rollback:
  - When wb_rollback_en=1 and wb_rollback_thread_idx matches in_thread_idx, the input is not captured: stage A valid is set to 0.
  - When wb_rollback_en=1 and wb_rollback_thread_idx matches stage A's thread, stage A does not advance: stage B valid is set to 0.
  - out_valid that is already registered is not affected.
  - Both checks apply in the same cycle, independently.
- The pipeline has no stall and no ready signal. A beat is accepted every cycle.

## Timing
- Latency is exactly 2 cycles: in_valid at edge N gives out_valid high after edge N+2. Throughput is 1 beat per cycle.
- Reset (reset_n=0 at a clock edge) clears both stage valids, out_valid, out_thread_idx, out_mask and out_result to 0. Stage A data registers are cleared as well.
- Reset asserted mid-operation discards all in-flight beats. out_valid is 0 on the first edge after release and stays 0 until a new input has travelled 2 stages.
- Data registers may update when their valid is 0, but out_result is only meaningful when out_valid=1.
- Back-to-back beats from different threads under a rollback: only the matching thread's beats are dropped. Order is preserved.

## Test plan
- **1.0 and carry:** sig=0x04000000, exp=127, sign=0 → 0x3f800000. sig=0x08000000, exp=127 → 0x40000000. Both with out_valid exactly 2 cycles after input.
- **Rounding:**
  - sig=0x04000004 (tie, LSB even) → 0x3f800000.
  - sig=0x0400000C (tie, LSB odd) → 0x3f800002.
  - sig=0x07FFFFFC, exp=127 → carry out → 0x40000000.
- **Limits:**
  - exp=254, sig=0x08000000 → 0x7f800000.
  - exp=1, sig=0x02000000 → 0x00000000.
  - sig=0, sign=1 → 0x80000000.
  - in_is_nan → 0x7fffffff.
  - in_is_inf with sign=1 → 0xff800000.
  - in_is_ftoi with sig=0xFFFFFFF9 → 0xFFFFFFF9.
- **Normalization shift:** sig=0x00000040, exp=150 → lz=20, exp 130, value 0x41000000.
- **Rollback:**
  - Issue thread 1 and thread 2 beats on consecutive cycles. Pulse rollback for thread 1 while its beat is in stage A. Only thread 2's result appears, 2 cycles after its issue.
  - Rollback matching the input thread drops that beat.
- **Reset:** fill the pipeline with 2 valid beats, then hold reset_n=0 for 1 cycle. All outputs are 0 and no stale out_valid appears afterwards. A new beat issued 1 cycle after release emerges 2 cycles later.
